// File: rtl/wdata_mux_n.sv
// N-master to 1-slave write-data multiplexer: latches an arbiter grant for a
// whole burst and forwards the selected master's beats through a 2-entry skid buffer.
module wdata_mux_n #(
    parameter int DATA_W    = 32,
    parameter int N_MASTERS = 4,
    parameter int SEL_W     = 2,
    parameter int CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          grant_valid,
    input  logic [SEL_W-1:0]              grant_idx,
    output logic                          grant_ack,
    input  logic [N_MASTERS*DATA_W-1:0]   s_wdata,
    input  logic [N_MASTERS-1:0]          s_wvalid,
    input  logic [N_MASTERS-1:0]          s_wlast,
    output logic [N_MASTERS-1:0]          s_wready,
    output logic [DATA_W-1:0]             m_wdata,
    output logic                          m_wvalid,
    output logic                          m_wlast,
    input  logic                          m_wready,
    output logic                          busy,
    output logic [SEL_W-1:0]              sel_q,
    output logic [CNT_W-1:0]              beat_cnt,
    output logic                          grant_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // One extra bit so an out-of-range index is representable in the compare.
    localparam logic [SEL_W:0] N_IDX = (SEL_W + 1)'(N_MASTERS);

    state_t                r_state;
    state_t                w_next_state;
    logic [SEL_W-1:0]      r_sel;
    logic                  r_grant_ack;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_err;
    logic                  r_out_v;
    logic [DATA_W-1:0]     r_out_data;
    logic                  r_out_last;
    logic                  r_skid_full;
    logic [DATA_W-1:0]     r_skid_data;
    logic                  r_skid_last;

    logic [N_MASTERS-1:0]  w_sel_oh;
    logic [DATA_W-1:0]     w_in_data;
    logic                  w_in_valid;
    logic                  w_in_last;
    logic                  w_idx_ok;
    logic                  w_latch;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_pop;
    logic [N_MASTERS-1:0]  w_wready;
    logic                  w_busy;

    function automatic logic idx_in_range(input logic [SEL_W-1:0] idx);
        return ({1'b0, idx} < N_IDX);
    endfunction

    // AND-OR mux of the latched master's data/valid/last lines.
    always_comb begin
        w_in_data = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            w_sel_oh[i] = (r_sel == SEL_W'(i));
            w_in_data   = w_in_data | (s_wdata[i*DATA_W +: DATA_W] & {DATA_W{w_sel_oh[i]}});
        end
        w_in_valid = |(s_wvalid & w_sel_oh);
        w_in_last  = |(s_wlast & w_sel_oh);
    end

    // Handshake qualifiers shared by the FSM and the buffer.
    always_comb begin
        w_idx_ok = idx_in_range(grant_idx);
        w_latch  = (r_state == ST_IDLE) && grant_valid && w_idx_ok;
        w_accept = (r_state == ST_DATA) && !r_skid_full && w_in_valid;
        w_load   = !r_out_v || m_wready;
        w_pop    = r_out_v && m_wready;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; grants are ignored once a burst is in progress.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_latch) begin
                    w_next_state = ST_DATA;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_accept && w_in_last) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DRAIN: begin
                if (!r_out_v && !r_skid_full) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: only the latched master may see ready, and only with skid room.
    always_comb begin
        w_wready = '0;
        w_busy   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
            end
            ST_DATA: begin
                if (!r_skid_full) begin
                    w_wready = w_sel_oh;
                end else begin
                    w_wready = '0;
                end
            end
            ST_DRAIN: begin
                w_wready = '0;
            end
            default: begin
                w_wready = '0;
                w_busy   = 1'b0;
            end
        endcase
    end

    // Grant latch, ack pulse, sticky error flag and saturating beat counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sel       <= '0;
            r_grant_ack <= 1'b0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_grant_ack <= w_latch;
            if (w_latch) begin
                r_sel <= grant_idx;
                r_cnt <= '0;
            end else if (w_pop && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_cnt <= r_cnt;
            end
            if ((r_state == ST_IDLE) && grant_valid && !w_idx_ok) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end

    // Output register plus skid register; skid refills output first to keep order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_v     <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_skid_full <= 1'b0;
            r_skid_data <= '0;
            r_skid_last <= 1'b0;
        end else if (w_load) begin
            if (r_skid_full) begin
                r_out_v     <= 1'b1;
                r_out_data  <= r_skid_data;
                r_out_last  <= r_skid_last;
                r_skid_full <= 1'b0;
            end else if (w_accept) begin
                r_out_v    <= 1'b1;
                r_out_data <= w_in_data;
                r_out_last <= w_in_last;
            end else begin
                r_out_v <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_full <= 1'b1;
            r_skid_data <= w_in_data;
            r_skid_last <= w_in_last;
        end else begin
            r_skid_full <= r_skid_full;
        end
    end

    assign grant_ack = r_grant_ack;
    assign s_wready  = w_wready;
    assign m_wdata   = r_out_data;
    assign m_wvalid  = r_out_v;
    assign m_wlast   = r_out_last;
    assign busy      = w_busy;
    assign sel_q     = r_sel;
    assign beat_cnt  = r_cnt;
    assign grant_err = r_err;

endmodule

// File: tb/tb_wdata_mux_n.sv
// Bench for wdata_mux_n: a queue-based model checked every cycle, plus directed
// bursts with hand-computed literal expectations (order, stalls, grant masking, reset).
module tb_wdata_mux_n;

    logic         clk = 1'b0;
    logic         rstn;
    logic         grant_valid;
    logic [2:0]   grant_idx;
    logic         grant_ack;
    logic [127:0] s_wdata;
    logic [3:0]   s_wvalid;
    logic [3:0]   s_wlast;
    logic [3:0]   s_wready;
    logic [31:0]  m_wdata;
    logic         m_wvalid;
    logic         m_wlast;
    logic         m_wready;
    logic         busy;
    logic [2:0]   sel_q;
    logic [7:0]   beat_cnt;
    logic         grant_err;

    // A 3-bit grant index lets out-of-range values (e.g. 5) reach a 4-master mux.
    wdata_mux_n #(.DATA_W(32), .N_MASTERS(4), .SEL_W(3), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .grant_valid(grant_valid), .grant_idx(grant_idx),
        .grant_ack(grant_ack), .s_wdata(s_wdata), .s_wvalid(s_wvalid),
        .s_wlast(s_wlast), .s_wready(s_wready), .m_wdata(m_wdata),
        .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
        .busy(busy), .sel_q(sel_q), .beat_cnt(beat_cnt), .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0=idle 1=data 2=drain; the buffer is just a queue of at most 2 beats.
    typedef struct packed { logic [31:0] d; logic l; } beat_t;
    beat_t       mq[$];
    int          mst;
    int          msel;
    int          mcnt;
    logic        merr;
    logic        mack;
    logic [31:0] obs[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                mq.delete(); mst = 0; msel = 0; mcnt = 0; merr = 1'b0; mack = 1'b0;
                chk("rst_outs", {12'd0, m_wvalid, m_wlast, m_wdata, s_wready, grant_ack,
                                 sel_q, beat_cnt, grant_err, busy}, 64'd0);
            end else begin
                bit pop, acc, empty_now;
                logic [3:0] exp_rdy;
                exp_rdy = (mst == 1 && mq.size() < 2) ? (4'd1 << msel) : 4'd0;
                chk("m_wvalid", m_wvalid, mq.size() > 0);
                if (mq.size() > 0) begin
                    chk("m_wdata", m_wdata, mq[0].d);
                    chk("m_wlast", m_wlast, mq[0].l);
                end
                chk("s_wready", s_wready, exp_rdy);
                chk("grant_ack", grant_ack, mack);
                chk("busy", busy, mst != 0);
                chk("sel_q", sel_q, 3'(msel));
                chk("beat_cnt", beat_cnt, 8'(mcnt));
                chk("grant_err", grant_err, merr);
                if (m_wvalid && m_wready) obs.push_back(m_wdata);
                // advance the model over the coming rising edge
                pop       = (mq.size() > 0) && m_wready;
                acc       = (mst == 1) && s_wvalid[msel] && (mq.size() < 2);
                empty_now = (mq.size() == 0);
                mack      = 1'b0;
                if (pop && mcnt < 255) mcnt++;
                case (mst)
                    0: if (grant_valid) begin
                        if (grant_idx < 3'd4) begin
                            msel = int'(grant_idx); mack = 1'b1; mcnt = 0; mst = 1;
                        end else begin
                            merr = 1'b1;
                        end
                    end
                    1: if (acc && s_wlast[msel]) mst = 2;
                    default: if (empty_now) mst = 0;
                endcase
                if (pop) void'(mq.pop_front());
                if (acc) mq.push_back('{d: s_wdata[msel*32 +: 32], l: s_wlast[msel]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        grant_valid = 1'b0; grant_idx = 3'd0; s_wvalid = 4'd0; s_wlast = 4'd0; m_wready = 1'b1;
    endtask

    logic [3:0]  snap_ready;
    logic [2:0]  snap_sel;
    logic        snap_ack;
    logic [31:0] snap_data;
    logic        snap_valid;

    // Grant master m, push n beats base..base+n-1, slave stalls where stall bit set.
    task automatic run_burst(input int m, input logic [31:0] base, input int n,
                             input logic [31:0] stall, input int inj_cyc,
                             input int snap_cyc, output int cycles);
        int sent = 0;
        int cyc = 0;
        bit accepted;
        grant_valid = 1'b1; grant_idx = 3'(m);
        step();
        grant_valid = 1'b0;
        while ((sent < n || busy) && cyc < 60) begin
            m_wready = (cyc < 32) ? !stall[cyc[4:0]] : 1'b1;
            if (sent < n) begin
                s_wdata[m*32 +: 32] = base + 32'(sent);
                s_wvalid[m[1:0]]    = 1'b1;
                s_wlast[m[1:0]]     = (sent == n - 1);
            end else begin
                s_wvalid[m[1:0]] = 1'b0;
                s_wlast[m[1:0]]  = 1'b0;
            end
            if (cyc == inj_cyc) begin
                grant_valid = 1'b1; grant_idx = 3'd1;
                s_wdata[63:32] = 32'hBAD1; s_wvalid[1] = 1'b1; s_wlast[1] = 1'b1;
            end else if (m != 1) begin
                grant_valid = 1'b0; s_wvalid[1] = 1'b0; s_wlast[1] = 1'b0;
            end else begin
                grant_valid = 1'b0;
            end
            if (cyc == snap_cyc) begin
                snap_ready = s_wready; snap_sel = sel_q; snap_ack = grant_ack;
                snap_data = m_wdata; snap_valid = m_wvalid;
            end
            accepted = (sent < n) && s_wready[m[1:0]];
            step();
            if (accepted) sent++;
            cyc++;
        end
        chk("burst_drained", {63'd0, (sent == n) && !busy}, 64'd1);
        cycles = cyc;
        idle_inputs();
    endtask

    task automatic chk_log(input string name, input logic [31:0] base, input int n);
        chk({name, "_len"}, 64'(obs.size()), 64'(n));
        for (int i = 0; i < n && i < obs.size(); i++) chk(name, obs[i], base + 32'(i));
    endtask

    initial begin
        int cyc;
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        // T1: reset with random inputs
        rstn = 1'b0; s_wdata = '0; idle_inputs();
        for (int i = 0; i < 6; i++) begin
            s_wdata = {$urandom, $urandom, $urandom, $urandom};
            s_wvalid = 4'($urandom); s_wlast = 4'($urandom); m_wready = 1'($urandom);
            grant_valid = 1'($urandom); grant_idx = 3'($urandom);
            step();
        end
        idle_inputs();
        #2 rstn = 1'b1;
        step();
        chk("t1_busy", busy, 1'b0);
        chk("t1_mvalid", m_wvalid, 1'b0);

        // T2: plain burst from master 2
        obs.delete();
        run_burst(2, 32'hA0, 4, 32'h0, -1, 0, cyc);
        chk("t2_ack", snap_ack, 1'b1);
        chk("t2_sel", snap_sel, 3'd2);
        chk("t2_ready", snap_ready, 4'b0100);
        chk("t2_cycles", 64'(cyc), 64'd6);
        chk("t2_cnt", beat_cnt, 8'd4);
        chk_log("t2_order", 32'hA0, 4);

        // T3: slave stalls 3 cycles after the first beat
        obs.delete();
        run_burst(2, 32'hA0, 4, 32'hE, -1, 2, cyc);
        chk("t3_ready_low", snap_ready, 4'b0000);
        chk("t3_held_data", snap_data, 32'hA0);
        chk("t3_held_valid", snap_valid, 1'b1);
        chk("t3_cycles", 64'(cyc), 64'd9);
        chk_log("t3_order", 32'hA0, 4);

        // T4: competing grant and master-1 beat during a burst
        obs.delete();
        run_burst(2, 32'hA0, 4, 32'h0, 1, 2, cyc);
        chk("t4_no_ack", snap_ack, 1'b0);
        chk("t4_sel", snap_sel, 3'd2);
        chk("t4_ready", snap_ready, 4'b0100);
        chk_log("t4_order", 32'hA0, 4);

        // T5: out-of-range grant then a valid one
        grant_valid = 1'b1; grant_idx = 3'd5;
        step();
        grant_valid = 1'b0;
        chk("t5_err", grant_err, 1'b1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_ack", grant_ack, 1'b0);
        obs.delete();
        run_burst(0, 32'hB0, 2, 32'h0, -1, 0, cyc);
        chk("t5_ack_ok", snap_ack, 1'b1);
        chk("t5_err_sticky", grant_err, 1'b1);
        chk_log("t5_order", 32'hB0, 2);

        // T6: reset mid-burst with skid full
        grant_valid = 1'b1; grant_idx = 3'd3;
        step();
        grant_valid = 1'b0; m_wready = 1'b0;
        s_wdata[127:96] = 32'hD0; s_wvalid[3] = 1'b1; s_wlast[3] = 1'b0;
        step();
        s_wdata[127:96] = 32'hD1;
        step();
        chk("t6_full_ready", s_wready, 4'b0000);
        chk("t6_full_valid", m_wvalid, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_async_valid", m_wvalid, 1'b0);
        chk("t6_async_busy", busy, 1'b0);
        idle_inputs();
        step(); step();
        #2 rstn = 1'b1;
        step();
        obs.delete();
        run_burst(3, 32'hE0, 3, 32'h0, -1, 0, cyc);
        chk("t6_cnt", beat_cnt, 8'd3);
        chk_log("t6_fresh", 32'hE0, 3);

        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
